// File: rtl/cache_arbiter_pkg.sv
// Shared LC-3b types used by the memory arbiter: line type, arbiter FSM
// states and the grant side used for round-robin tie-breaking.
package lc3b_types;

   typedef logic [15:0]  lc3b_word;
   typedef logic [127:0] lc3b_line;

   typedef enum logic [1:0] {
      arb_idle    = 2'd0,
      arb_serve_i = 2'd1,
      arb_serve_d = 2'd2
   } lc3b_arb_state;

   typedef enum logic {
      arb_i = 1'b0,
      arb_d = 1'b1
   } lc3b_arb_side;

endpackage

// File: rtl/cache_arbiter_sat_counter.sv
// Saturating up-counter: increments when inc is high, holds at all-ones,
// cleared only by the asynchronous reset.
module arb_sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   output logic [WIDTH-1:0] cnt
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   // Next count: step by one unless already pinned at the maximum.
   always_comb begin
      cnt_d = cnt_q;
      if (inc && (cnt_q != {WIDTH{1'b1}}))
         cnt_d = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
   end

   // Count register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/cache_arbiter.sv
// Arbiter sharing the single physical-memory port between the icache and
// dcache. One whole-line transaction at a time; ties broken round-robin.
// The granted request is registered so pmem never sees live cache inputs.
module cache_arbiter
   import lc3b_types::*;
#(
   parameter int ADDR_WIDTH = 16,
   parameter int LINE_WIDTH = 128,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_read,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   output logic [LINE_WIDTH-1:0] i_rdata,
   output logic                  i_resp,
   input  logic                  d_read,
   input  logic                  d_write,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [LINE_WIDTH-1:0] d_wdata,
   output logic [LINE_WIDTH-1:0] d_rdata,
   output logic                  d_resp,
   output logic                  pmem_read,
   output logic                  pmem_write,
   output logic [ADDR_WIDTH-1:0] pmem_address,
   output logic [LINE_WIDTH-1:0] pmem_wdata,
   input  logic [LINE_WIDTH-1:0] pmem_rdata,
   input  logic                  pmem_resp,
   output logic                  busy,
   output logic [CNT_WIDTH-1:0]  contention_cnt
);

   lc3b_arb_state               state_q, state_d;
   lc3b_arb_side                last_grant_q, last_grant_d;
   logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
   logic [LINE_WIDTH-1:0]       wdata_q, wdata_d;
   logic                        op_write_q, op_write_d;
   logic                        i_req, d_req, grant_i, grant_d;
   logic                        contend;

   assign i_req = i_read;
   assign d_req = d_read | d_write;

   // Grant decision in IDLE; on a tie the side not served last wins.
   always_comb begin
      grant_i = 1'b0;
      grant_d = 1'b0;
      if (state_q == arb_idle) begin
         if (i_req && d_req) begin
            grant_d = (last_grant_q == arb_i);
            grant_i = (last_grant_q == arb_d);
         end else begin
            grant_d = d_req;
            grant_i = i_req;
         end
      end
   end

   // Next state and request latches; serve states only exit on pmem_resp,
   // so a request still high in the resp cycle cannot be regranted.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      op_write_d   = op_write_q;
      case (state_q)
         arb_idle: begin
            if (grant_d) begin
               state_d      = arb_serve_d;
               last_grant_d = arb_d;
               addr_d       = d_addr;
               wdata_d      = d_wdata;
               op_write_d   = d_write; // read+write together is a writeback
            end else if (grant_i) begin
               state_d      = arb_serve_i;
               last_grant_d = arb_i;
               addr_d       = i_addr;
               op_write_d   = 1'b0;
            end
         end
         arb_serve_i, arb_serve_d: begin
            if (pmem_resp) state_d = arb_idle;
         end
         default: state_d = arb_idle;
      endcase
   end

   // Arbiter state registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= arb_idle;
         last_grant_q <= arb_i;
         addr_q       <= '0;
         wdata_q      <= '0;
         op_write_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         op_write_q   <= op_write_d;
      end
   end

   // Strobes come only from the latched op, so reset drops them at once.
   always_comb begin
      pmem_read  = (state_q == arb_serve_i) ||
                   ((state_q == arb_serve_d) && !op_write_q);
      pmem_write = (state_q == arb_serve_d) && op_write_q;
      i_resp     = (state_q == arb_serve_i) && pmem_resp;
      d_resp     = (state_q == arb_serve_d) && pmem_resp;
      // Read data is only meaningful with resp; zeroed otherwise.
      i_rdata    = i_resp ? pmem_rdata : '0;
      d_rdata    = d_resp ? pmem_rdata : '0;
   end

   assign pmem_address = addr_q;
   assign pmem_wdata   = wdata_q;
   assign busy         = (state_q != arb_idle);

   // A cycle counts as contention when the side not being served is waiting.
   assign contend = ((state_q == arb_serve_i) && d_req) ||
                    ((state_q == arb_serve_d) && i_req);

   arb_sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (contend),
      .cnt   (contention_cnt)
   );

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter. A second instance with a 4-bit counter
// shares the inputs so saturation can be observed next to the 16-bit count.
module tb_cache_arbiter;

   logic          clk = 1'b0;
   logic          reset;
   logic          i_read, d_read, d_write, pmem_resp;
   logic [15:0]   i_addr, d_addr;
   logic [127:0]  d_wdata, pmem_rdata;
   logic [127:0]  i_rdata, d_rdata, pmem_wdata;
   logic          i_resp, d_resp, pmem_read, pmem_write, busy;
   logic [15:0]   pmem_address, contention_cnt;

   logic [127:0]  i_rdata4, d_rdata4, pmem_wdata4;
   logic          i_resp4, d_resp4, pmem_read4, pmem_write4, busy4;
   logic [15:0]   pmem_address4;
   logic [3:0]    cnt4;

   int tests = 0;
   int fails = 0;

   localparam logic [127:0] A5 = {16{8'hA5}};

   always #5 clk = ~clk;

   cache_arbiter dut (
      .clk(clk), .reset(reset),
      .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
      .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_resp(d_resp),
      .pmem_read(pmem_read), .pmem_write(pmem_write),
      .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
      .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
      .busy(busy), .contention_cnt(contention_cnt)
   );

   cache_arbiter #(.CNT_WIDTH(4)) dut4 (
      .clk(clk), .reset(reset),
      .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata4), .i_resp(i_resp4),
      .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata4), .d_resp(d_resp4),
      .pmem_read(pmem_read4), .pmem_write(pmem_write4),
      .pmem_address(pmem_address4), .pmem_wdata(pmem_wdata4),
      .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
      .busy(busy4), .contention_cnt(cnt4)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   // Move into the next cycle window (just after the rising edge).
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Let combinational outputs settle after driving inputs.
   task automatic settle();
      #2;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      i_read = 0; d_read = 0; d_write = 0; pmem_resp = 0;
      tick(); tick();
      reset = 1'b0;
   endtask

   initial begin
      i_addr = '0; d_addr = '0; d_wdata = '0; pmem_rdata = '0;
      do_reset();
      settle();
      // Reset state
      chk("rst_busy",  busy, 0);
      chk("rst_rd",    pmem_read, 0);
      chk("rst_wr",    pmem_write, 0);
      chk("rst_addr",  pmem_address, 0);
      chk("rst_wdata", pmem_wdata, 0);
      chk("rst_cnt",   contention_cnt, 0);
      chk("rst_iresp", i_resp, 0);
      chk("rst_dresp", d_resp, 0);

      // 1: lone icache read, pmem answers on the third serve cycle
      i_read = 1; i_addr = 16'h0040;
      settle();
      chk("t1_idle_rd", pmem_read, 0);
      tick(); settle();
      chk("t1_rd",    pmem_read, 1);
      chk("t1_addr",  pmem_address, 16'h0040);
      chk("t1_wr",    pmem_write, 0);
      chk("t1_iresp0", i_resp, 0);
      tick(); settle();
      chk("t1_iresp1", i_resp, 0);
      tick();
      pmem_resp = 1; pmem_rdata = A5;
      settle();
      chk("t1_iresp", i_resp, 1);
      chk("t1_rdata", i_rdata, A5);
      chk("t1_dresp", d_resp, 0);
      tick();
      pmem_resp = 0; i_read = 0;
      settle();
      chk("t1_done_resp", i_resp, 0);
      chk("t1_done_busy", busy, 0);
      chk("t1_cnt", contention_cnt, 0);

      // 2: simultaneous I read and D write after reset -> D first
      do_reset();
      i_read = 1; i_addr = 16'h0080;
      d_write = 1; d_addr = 16'h1000; d_wdata = 128'h1234;
      tick(); settle();
      chk("t2_wr",    pmem_write, 1);
      chk("t2_rd",    pmem_read, 0);
      chk("t2_addr",  pmem_address, 16'h1000);
      chk("t2_wdata", pmem_wdata, 128'h1234);
      chk("t2_cnt0",  contention_cnt, 0);
      tick();
      tick();
      pmem_resp = 1;
      settle();
      chk("t2_dresp", d_resp, 1);
      chk("t2_iresp", i_resp, 0);
      chk("t2_cnt2",  contention_cnt, 2);
      tick();
      pmem_resp = 0; d_write = 0;
      settle();
      chk("t2_idle", busy, 0);
      chk("t2_cnt3", contention_cnt, 3);
      tick();
      pmem_resp = 1; pmem_rdata = 128'hBEEF;
      settle();
      chk("t2_i_rd",    pmem_read, 1);
      chk("t2_i_addr",  pmem_address, 16'h0080);
      chk("t2_i_resp",  i_resp, 1);
      chk("t2_i_rdata", i_rdata, 128'hBEEF);
      tick();
      pmem_resp = 0; i_read = 0;
      settle();
      chk("t2_cnt_final", contention_cnt, 3);

      // 3: both held continuously -> D, I, D, I
      do_reset();
      i_read = 1; i_addr = 16'h0100;
      d_read = 1; d_addr = 16'h0200;
      for (int k = 0; k < 4; k++) begin
         tick();
         pmem_resp = 1;
         settle();
         chk("t3_addr", pmem_address, (k % 2 == 0) ? 16'h0200 : 16'h0100);
         chk("t3_dresp", d_resp, (k % 2 == 0) ? 1'b1 : 1'b0);
         chk("t3_iresp", i_resp, (k % 2 == 0) ? 1'b0 : 1'b1);
         tick();
         pmem_resp = 0;
         settle();
         chk("t3_gap", busy, 0);
      end
      i_read = 0; d_read = 0;

      // 4: read+write together is a write only
      do_reset();
      d_read = 1; d_write = 1; d_addr = 16'h2000; d_wdata = 128'h55;
      tick(); settle();
      chk("t4_wr",   pmem_write, 1);
      chk("t4_rd",   pmem_read, 0);
      chk("t4_addr", pmem_address, 16'h2000);
      pmem_resp = 1;
      settle();
      chk("t4_dresp", d_resp, 1);
      chk("t4_rd2",   pmem_read, 0);
      tick();
      pmem_resp = 0; d_read = 0; d_write = 0;

      // 5: reset two cycles into SERVE_I
      do_reset();
      i_read = 1; i_addr = 16'h0300;
      tick(); settle();
      chk("t5_rd", pmem_read, 1);
      tick();
      reset = 1;
      #1;
      chk("t5_async_rd", pmem_read, 0);
      chk("t5_async_busy", busy, 0);
      chk("t5_async_addr", pmem_address, 0);
      pmem_resp = 1;
      #1;
      chk("t5_no_iresp", i_resp, 0);
      tick();
      reset = 0; i_read = 0; pmem_resp = 0;
      tick();
      pmem_resp = 1;
      settle();
      chk("t5_idle_iresp", i_resp, 0);
      chk("t5_idle_dresp", d_resp, 0);
      chk("t5_idle_busy",  busy, 0);
      tick();
      pmem_resp = 0;

      // 6: sustained contention, 4-bit counter saturates
      do_reset();
      i_read = 1; i_addr = 16'h0400;
      d_read = 1; d_addr = 16'h0500;
      tick();
      for (int k = 0; k < 14; k++) tick();
      settle();
      chk("t6_cnt4_14", cnt4, 4'hE);
      for (int k = 0; k < 6; k++) tick();
      settle();
      chk("t6_cnt4_sat", cnt4, 4'hF);
      chk("t6_cnt16",    contention_cnt, 16'd20);
      pmem_resp = 1;
      tick();
      pmem_resp = 0; i_read = 0; d_read = 0;
      tick(); settle();
      chk("t6_cnt4_hold", cnt4, 4'hF);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Absolute time bound so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
Shares the single physical-memory port between the instruction-side cache (mem1 path) and the data-side cache (mem2 path) of the pipelined LC-3b datapath. Each cache issues whole-line read or write transactions. The arbiter grants one cache at a time, registers the granted request, forwards it to pmem, and routes pmem_resp/rdata back to that cache. It sits between the L1 caches and physical memory, below the pipeline stall logic.

Parameters:
ADDR_WIDTH, 16, byte address width (lc3b_word)
LINE_WIDTH, 128, cache line width in bits
CNT_WIDTH, 16, width of saturating contention counter

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
i_read  in  1  icache line-read request, held until i_resp
i_addr  in  ADDR_WIDTH  icache line address
i_rdata  out  LINE_WIDTH  line data to icache, valid with i_resp
i_resp  out  1  one-cycle completion pulse to icache
d_read  in  1  dcache line-read request, held until d_resp
d_write  in  1  dcache line-write (writeback) request, held until d_resp
d_addr  in  ADDR_WIDTH  dcache line address
d_wdata  in  LINE_WIDTH  writeback data
d_rdata  out  LINE_WIDTH  line data to dcache, valid with d_resp
d_resp  out  1  one-cycle completion pulse to dcache
pmem_read  out  1  memory read strobe, held until pmem_resp
pmem_write  out  1  memory write strobe, held until pmem_resp
pmem_address  out  ADDR_WIDTH  registered address of granted request
pmem_wdata  out  LINE_WIDTH  registered write data
pmem_rdata  in  LINE_WIDTH  memory read data, valid with pmem_resp
pmem_resp  in  1  memory completion pulse
busy  out  1  high while in a SERVE state
contention_cnt  out  CNT_WIDTH  saturating count of cycles a requester waited on the other

Behaviour:
- FSM states: IDLE, SERVE_I, SERVE_D. Reset state is IDLE. last_grant resets to I.
- Reset values: all outputs 0, pmem_address/pmem_wdata regs 0, contention_cnt 0.
- IDLE:
  - Only i_read pending -> SERVE_I.
  - Only d_read or d_write pending -> SERVE_D.
  - Both pending -> grant the side opposite last_grant (round-robin). After reset, D wins first.
  - On the grant edge: latch address (and for D, wdata and op) into regs; update last_grant.
- SERVE_x:
  - pmem_read or pmem_write is driven from the latched op, never from live inputs.
  - On pmem_resp: x_resp=1 in the same cycle (combinational), x_rdata=pmem_rdata, then next state IDLE.
  - i_rdata/d_rdata are a pmem_rdata passthrough and are don't-care when resp=0.
- Latency: request seen in IDLE at cycle t -> pmem strobe at t+1 -> x_resp in the pmem_resp cycle. At least one IDLE cycle between transactions; a request still high in the resp cycle is never regranted.
- d_read and d_write both high: treated as a write; reads are never issued for that transaction.
- Requester drops its request mid-service: the transaction still completes and resp still pulses (pmem cannot abort).
- pmem_resp while in IDLE: ignored, no resp output.
- Reset mid-transaction: immediate return to IDLE, strobes deassert asynchronously, and no resp is issued.
- contention_cnt: +1 each cycle in SERVE_I with d_read|d_write high, or in SERVE_D with i_read high. Saturates at all-ones with no wrap. Cleared only by reset.
- busy = (state != IDLE).

Decomposition:
- Package lc3b_types gains: typedef lc3b_line (logic [127:0]), enum lc3b_arb_state {arb_idle, arb_serve_i, arb_serve_d}, enum lc3b_arb_side {arb_i, arb_d}.
- One natural sub-module: arb_sat_counter (parameterised width; increment and async reset; holds at max).

Test Plan:
1. i_read=1, i_addr=16'h0040 alone; pmem_resp after 3 cycles with pmem_rdata=128'hA5..A5 -> pmem_read=1 and pmem_address=16'h0040 from cycle t+1; i_resp pulses once with i_rdata=A5..A5; d_resp stays 0.
2. i_read and d_write asserted together after reset (d_addr=16'h1000, d_wdata=128'h1234) -> D served first (pmem_write=1, pmem_wdata=128'h1234). Then after one IDLE cycle I is served. contention_cnt equals the SERVE_D cycle count.
3. Both requests held continuously for 4 transactions -> grants alternate D, I, D, I.
4. d_read=d_write=1, d_addr=16'h2000 -> only pmem_write asserted; d_resp on pmem_resp.
5. Assert reset 2 cycles into SERVE_I -> pmem_read drops immediately, no i_resp, state IDLE. A later pmem_resp is ignored.
6. CNT_WIDTH=4, hold contention for 20 cycles -> contention_cnt stops at 4'hF.
